// File: rtl/nn_dense_layer.sv
// Fully-connected layer stage: N_OUT dot products of N_IN streamed activations plus bias,
// followed by ReLU with saturation into registered, packed results.
//
// state | meaning
// IDLE  | weight loading allowed; waits for req with fill low
// RUN   | streams activations, accumulates one product per cycle for neuron j
// ACT   | ReLU/saturate, write result j, reload bias for next neuron
// DONE  | results valid; ack_layer held while req stays high
module nn_dense_layer #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int DW    = 8,
    parameter int FRAC  = 4,
    parameter int ACCW  = 20,
    parameter int IN_AW = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req,
    input  logic                                       fill,
    input  logic                                       w_wr,
    input  logic [DW-1:0]                              w_data,
    output logic [IN_AW-1:0]                           in_addr,
    input  logic [DW-1:0]                              in_data,
    output logic [N_OUT*DW-1:0]                        out_data,
    output logic                                       out_wr,
    output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] out_idx,
    output logic                                       busy,
    output logic                                       ack_layer
);

    localparam int NW  = N_OUT * (N_IN + 1);
    localparam int WAW = (NW > 1) ? $clog2(NW) : 1;
    localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW  = $clog2(N_IN + 2);
    localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((1 << (DW - 1)) - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [DW-1:0]          wram [NW];
    logic [WAW-1:0]         w_ptr;
    logic [JW-1:0]          j, j_nxt;
    logic [KW-1:0]          k;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] y;
    logic [DW-1:0]          sat;
    logic [WAW-1:0]         w_idx, bias_nxt_idx;
    logic signed [2*DW-1:0] prod;
    logic                   wr_en, start, last_neuron;

    function automatic logic signed [ACCW-1:0] bias_scaled(input logic [DW-1:0] b);
        logic signed [ACCW-1:0] ext;
        ext = {{(ACCW - DW){b[DW-1]}}, b};
        return ext <<< FRAC;
    endfunction

    always_comb begin
        wr_en        = (state == S_IDLE) && fill && w_wr;
        start        = (state == S_IDLE) && req && !fill;
        last_neuron  = (j == JW'(N_OUT - 1));
        j_nxt        = last_neuron ? '0 : j + 1'b1;
        w_idx        = WAW'(int'(j) * (N_IN + 1) + int'(k));
        bias_nxt_idx = WAW'(int'(j_nxt) * (N_IN + 1));
        prod         = $signed(in_data) * $signed(wram[w_idx]);
        busy         = (state == S_RUN) || (state == S_ACT);
        in_addr      = ((state == S_RUN) && (k < KW'(N_IN))) ? IN_AW'(k) : '0;
    end

    // Arithmetic shift truncates toward -inf; ReLU then clamps to the positive DW range.
    always_comb begin
        y = acc >>> FRAC;
        if (y < 0)
            sat = '0;
        else if (y > Y_MAX)
            sat = Y_MAX[DW-1:0];
        else
            sat = y[DW-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (k == KW'(N_IN)) state_nxt = S_ACT;
            S_ACT:  state_nxt = last_neuron ? S_DONE : S_RUN;
            S_DONE: if (!req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Weight RAM is deliberately not reset so coefficients survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            wram[w_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_wr    <= 1'b0;
            out_idx   <= '0;
            ack_layer <= 1'b0;
        end else begin
            out_wr    <= 1'b0;
            ack_layer <= (state == S_DONE) && req;
            if (wr_en)
                w_ptr <= (w_ptr == WAW'(NW - 1)) ? '0 : w_ptr + 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        j   <= '0;
                        k   <= '0;
                        acc <= bias_scaled(wram[0]);
                    end
                end
                S_RUN: begin
                    // in_data arriving now belongs to the address issued last cycle
                    if (k != '0)
                        acc <= acc + {{(ACCW - 2*DW){prod[2*DW-1]}}, prod};
                    k <= k + 1'b1;
                end
                S_ACT: begin
                    out_data[j*DW +: DW] <= sat;
                    out_wr               <= 1'b1;
                    out_idx              <= j;
                    if (!last_neuron) begin
                        j   <= j_nxt;
                        k   <= '0;
                        acc <= bias_scaled(wram[bias_nxt_idx]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_dense_layer.sv
// Directed bench for nn_dense_layer: hand-computed dot products, saturation, reset, handshake
// and weight-pointer behaviour at default parameters.
module tb_nn_dense_layer;

    logic        clk = 1'b0;
    logic        rst, req, fill, w_wr;
    logic [7:0]  w_data;
    logic [0:0]  in_addr;
    logic [7:0]  in_data;
    logic [15:0] out_data;
    logic        out_wr;
    logic [0:0]  out_idx;
    logic        busy, ack_layer;

    logic [7:0]  x_mem [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nn_dense_layer dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .fill     (fill),
        .w_wr     (w_wr),
        .w_data   (w_data),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_data (out_data),
        .out_wr   (out_wr),
        .out_idx  (out_idx),
        .busy     (busy),
        .ack_layer(ack_layer)
    );

    // synchronous activation memory: data one cycle after address
    always @(posedge clk) in_data <= x_mem[in_addr];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slice_of(input int j);
        return {24'b0, out_data[j*8 +: 8]};
    endfunction

    task automatic wr_word(input int v);
        fill   = 1'b1;
        w_wr   = 1'b1;
        w_data = 8'(v);
        step();
        w_wr   = 1'b0;
        fill   = 1'b0;
    endtask

    task automatic load6(input int a, input int b, input int c, input int d, input int e, input int f);
        wr_word(a); wr_word(b); wr_word(c); wr_word(d); wr_word(e); wr_word(f);
    endtask

    // Raises req and counts edges until ack; c=1 is the edge that samples req.
    task automatic run_wait(input bit poke, output int lat, output int p0, output int p1);
        lat = -1; p0 = -1; p1 = -1;
        req = 1'b1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            step();
            if (poke && c == 3) begin
                fill = 1'b1; w_wr = 1'b1; w_data = 8'd127;
            end else if (poke && c == 4) begin
                fill = 1'b0; w_wr = 1'b0;
            end
            if (out_wr) begin
                if (out_idx == 1'b0) p0 = c;
                else                 p1 = c;
            end
            if (ack_layer) lat = c;
        end
    endtask

    task automatic check_run(input string tag, input bit poke, input int e0, input int e1);
        int lat, p0, p1;
        run_wait(poke, lat, p0, p1);
        check_val({tag, "_ack_latency"}, lat, 10);
        check_val({tag, "_wr_idx0_cycle"}, p0, 5);
        check_val({tag, "_wr_idx1_cycle"}, p1, 9);
        check_val({tag, "_slice0"}, slice_of(0), e0);
        check_val({tag, "_slice1"}, slice_of(1), e1);
    endtask

    task automatic release_req(input string tag);
        req = 1'b0;
        step();
        check_val({tag, "_ack_drop"}, ack_layer, 0);
        check_val({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; fill = 1'b0; w_wr = 1'b0; w_data = '0;
        x_mem[0] = '0; x_mem[1] = '0;
        step(); step();
        check_val("rst_busy", busy, 0);
        check_val("rst_ack", ack_layer, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_wr", out_wr, 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_in_addr", in_addr, 0);
        rst = 1'b0;
        step();

        // basic: y0 = 16*32/16 = 32, y1 = (128 - 512)/16 = -24 -> 0
        load6(0, 32, 16, 8, -32, 0);
        x_mem[0] = 8'd16; x_mem[1] = 8'd0;
        check_run("t1", 1'b0, 32, 0);
        check_val("t1_done_busy", busy, 0);
        release_req("t1");

        // saturation: 2*127*127 = 32258 -> 2016 -> 127
        load6(0, 127, 127, 0, 127, 127);
        x_mem[0] = 8'd127; x_mem[1] = 8'd127;
        check_run("t2", 1'b0, 127, 127);
        release_req("t2");

        // bias only
        load6(-16, 0, 0, 16, 0, 0);
        check_run("t3", 1'b0, 0, 16);
        release_req("t3");

        // reset mid-RUN, weights retained
        load6(0, 32, 16, 8, -32, 0);
        x_mem[0] = 8'd16; x_mem[1] = 8'd0;
        req = 1'b1;
        step(); step(); step(); step();
        check_val("t4_busy_pre", busy, 1);
        rst = 1'b1; req = 1'b0;
        step();
        check_val("t4_rst_busy", busy, 0);
        check_val("t4_rst_ack", ack_layer, 0);
        check_val("t4_rst_out_data", out_data, 0);
        check_val("t4_rst_out_wr", out_wr, 0);
        rst = 1'b0;
        step();
        check_run("t4", 1'b0, 32, 0);

        // handshake: hold, drop, re-raise, fill blocks start
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t5_hold_ack", ack_layer, 1);
            check_val("t5_hold_out", out_data, 16'h0020);
        end
        release_req("t5");
        check_run("t5b", 1'b0, 32, 0);
        release_req("t5b");
        fill = 1'b1; req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t5_fill_block_busy", busy, 0);
        end
        check_val("t5_fill_block_ack", ack_layer, 0);
        fill = 1'b0;
        check_run("t5c", 1'b0, 32, 0);
        release_req("t5c");

        // pointer wrap: 7th word overwrites b0 -> y0 = (256 + 512)/16 = 48
        load6(99, 32, 16, 8, -32, 0);
        wr_word(16);
        check_run("t6", 1'b1, 48, 0);
        release_req("t6");
        check_run("t6_norun_write", 1'b0, 48, 0);
        release_req("t6b");
        // pointer sits at 1: w00 := 0 -> y0 = 256/16 = 16
        wr_word(0);
        check_run("t6_ptr", 1'b0, 16, 0);
        release_req("t6c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
